bist_march_ctrl: RTL
====================

// Module: bist_march_ctrl
// PURPOSE
//  March C- sequencer for the SRAM built-in self test. On start it walks the
//  SRAM through four data backgrounds, issuing one read or write per clock,
//  compares read data against the expected background and reports a sticky
//  pass/fail with the location of the first miscompare. Drives the SRAM port
//  directly; exports the current background pair for bench/debug monitoring.
// PARAMETERS
//  ADDR_W        5   SRAM address width; DEPTH = 2**ADDR_W words
//  DATA_W        32  SRAM word width; must be a multiple of 8
//  STOP_ON_FAIL  0   1: abort the run after the first miscompare; 0: run to end
// PORTS
//  clk          in   1       single clock, all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       level; sampled only in IDLE or DONE, starts a run
//  mem_cs       out  1       SRAM chip select, one access per asserted cycle
//  mem_we       out  1       1 = write, 0 = read (valid while mem_cs = 1)
//  mem_addr     out  ADDR_W  SRAM address
//  mem_wdata    out  DATA_W  SRAM write data
//  mem_rdata    in   DATA_W  SRAM read data, valid the cycle after the read
//  pattern_0    out  DATA_W  current background "0" value
//  pattern_1    out  DATA_W  current background "1" value (= ~pattern_0)
//  busy         out  1       high in RUN and DRAIN
//  bist_done    out  1       sticky; high in DONE
//  bist_fail    out  1       sticky; set on first miscompare of the run
//  fail_addr    out  ADDR_W  address of first miscompare
//  fail_elem    out  3       March element (0..5) of first miscompare
//  fail_bg      out  2       background index (0..3) of first miscompare
// BEHAVIOUR
//  - Reset: state IDLE; every output 0 (mem_*, pattern_*, busy, done, fail,
//    fail_*). Takes effect at the next edge; rst mid-run aborts, no SRAM access
//    follows, and the next start begins a full fresh run.
//  - All outputs registered. States: IDLE -> RUN -> DRAIN -> DONE.
//    IDLE/DONE: start=1 -> RUN; clears bist_done, bist_fail, fail_*; bg=0,
//    elem=0, addr=0. start is ignored in RUN and DRAIN.
//  - Backgrounds bg 0..3: pattern_0 = byte 8'h00/8'h55/8'h33/8'h0F replicated
//    to DATA_W; pattern_1 = ~pattern_0. "0"/"1" below mean pattern_0/pattern_1.
//  - Elements per bg: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1);
//    M4 down(r1,w0); M5 up(r0). up = addr 0..DEPTH-1, down = DEPTH-1..0.
//    All ops of an element complete at one address before the address steps.
//  - One op per cycle, no idle cycles between ops, elements or backgrounds:
//    10*DEPTH ops per bg, 40*DEPTH per run. mem_cs=1 on every RUN cycle.
//  - With start sampled at edge 0: ops drive cycles 1..40*DEPTH; DRAIN is cycle
//    40*DEPTH+1 (mem_cs=0, last read compared); bist_done=1 from 40*DEPTH+2.
//  - Compare: expected value, addr, elem, bg delayed one cycle with each read;
//    mismatch when mem_rdata != expected in the cycle after a read. First
//    mismatch sets bist_fail and loads fail_*; later mismatches change nothing.
//  - STOP_ON_FAIL=1: on a mismatch RUN goes to DRAIN next cycle (in-flight op
//    is the last), then DONE. STOP_ON_FAIL=0: run always completes.
//  - A write to the address just read is legal back-to-back; no forwarding.
//  - bist_done and bist_fail hold in DONE until rst or a new start.
// TESTING
//  1 rst=1 two cycles -> all outputs 0, mem_cs stays 0 with start=0.
//  2 Fault-free 32x32 model, 1-cycle start pulse -> 1280 accesses in order
//    (cycle 1: w addr0 32'h0; bg1 M0 writes 32'h55555555), bist_done at
//    cycle 1282, bist_fail=0, busy low from then.
//  3 Model with addr 5 bit 3 stuck-at-0 -> bist_fail=1, fail_addr=5,
//    fail_elem=2, fail_bg=0; run still ends with bist_done at cycle 1282.
//  4 STOP_ON_FAIL=1, same fault -> mem_cs=0 from cycle after the M2 read of
//    addr 5 + 1 (at most one extra op), bist_done two cycles after the miscompare.
//  5 rst pulsed at cycle 500 -> mem_cs=0, busy=0 next cycle; new start then
//    completes fault-free in 1282 cycles.
//  6 start held high through run and in DONE -> no restart until DONE; in DONE
//    a new run starts, clearing bist_done and prior bist_fail/fail_*.

Source files
------------

// File: rtl/bist_march_ctrl_if.sv
// rtl/bist_march_ctrl_if.sv - SRAM access port between the March C- BIST sequencer and the array
interface bist_march_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // sequencer side: drives the access, receives read data one cycle later
  modport master (
    output mem_cs,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  // array side
  modport slave (
    input  mem_cs,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/bist_march_ctrl.sv
// rtl/bist_march_ctrl.sv - March C- SRAM self-test sequencer with sticky pass/fail and first-fail capture
module bist_march_ctrl #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  bist_march_ctrl_if.master    mem,
  output logic [DATA_W-1:0]    pattern_0,
  output logic [DATA_W-1:0]    pattern_1,
  output logic                 busy,
  output logic                 bist_done,
  output logic                 bist_fail,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [2:0]           fail_elem,
  output logic [1:0]           fail_bg
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state;

  // Position of the op currently on the SRAM port. idx is the logical step
  // within the element; down elements map it to ~idx.
  logic [1:0]        bg;
  logic [2:0]        elem;
  logic [ADDR_W-1:0] idx;
  logic              ph;

  // Position and decoded access for the op that follows the current one
  logic [1:0]        nxt_bg;
  logic [2:0]        nxt_elem;
  logic [ADDR_W-1:0] nxt_idx;
  logic              nxt_ph;
  logic              nxt_we;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_p0;
  logic [DATA_W-1:0] nxt_data;
  logic              last_op;

  // Read-compare pipeline: what the read issued last cycle should return
  logic              chk_valid;
  logic [DATA_W-1:0] chk_exp;
  logic [ADDR_W-1:0] chk_addr;
  logic [2:0]        chk_elem;
  logic [1:0]        chk_bg;
  logic              miscmp;

  function automatic logic [DATA_W-1:0] bg_pattern(input logic [1:0] b);
    logic [7:0] byte_v;
    case (b)
      2'd0:    byte_v = 8'h00;
      2'd1:    byte_v = 8'h55;
      2'd2:    byte_v = 8'h33;
      default: byte_v = 8'h0F;
    endcase
    return {(DATA_W/8){byte_v}};
  endfunction

  // M0 and M5 are single-op elements; the others are read-then-write
  function automatic logic elem_last_ph(input logic [2:0] e);
    return !((e == 3'd0) || (e == 3'd5));
  endfunction

  function automatic logic op_is_write(input logic [2:0] e, input logic p);
    return (e == 3'd0) || (p && (e != 3'd5));
  endfunction

  // 1 when the op uses pattern_1: M1/M3 write "1", M2/M4 read "1"
  function automatic logic op_is_one(input logic [2:0] e, input logic p);
    case (e)
      3'd1, 3'd3: return p;
      3'd2, 3'd4: return !p;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic elem_is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Step the March position and decode the following access
  always_comb begin
    nxt_bg   = bg;
    nxt_elem = elem;
    nxt_idx  = idx;
    nxt_ph   = 1'b0;
    if (ph != elem_last_ph(elem)) begin
      nxt_ph = 1'b1;
    end else if (idx != '1) begin
      nxt_idx = idx + 1'b1;
    end else begin
      nxt_idx = '0;
      if (elem != 3'd5) begin
        nxt_elem = elem + 3'd1;
      end else begin
        nxt_elem = 3'd0;
        nxt_bg   = bg + 2'd1;
      end
    end
    last_op  = (bg == 2'd3) && (elem == 3'd5) && (idx == '1);
    nxt_we   = op_is_write(nxt_elem, nxt_ph);
    nxt_addr = elem_is_down(nxt_elem) ? ~nxt_idx : nxt_idx;
    nxt_p0   = bg_pattern(nxt_bg);
    nxt_data = op_is_one(nxt_elem, nxt_ph) ? ~nxt_p0 : nxt_p0;
    miscmp   = chk_valid && (mem.mem_rdata != chk_exp);
  end

  // Sequencer FSM with registered SRAM port, status and first-fail capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bg            <= '0;
      elem          <= '0;
      idx           <= '0;
      ph            <= 1'b0;
      mem.mem_cs    <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      pattern_0     <= '0;
      pattern_1     <= '0;
      busy          <= 1'b0;
      bist_done     <= 1'b0;
      bist_fail     <= 1'b0;
      fail_addr     <= '0;
      fail_elem     <= '0;
      fail_bg       <= '0;
      chk_valid     <= 1'b0;
      chk_exp       <= '0;
      chk_addr      <= '0;
      chk_elem      <= '0;
      chk_bg        <= '0;
    end else begin
      // Reads also drive their expected value on wdata, so the port holds it
      chk_valid <= mem.mem_cs && !mem.mem_we;
      chk_exp   <= mem.mem_wdata;
      chk_addr  <= mem.mem_addr;
      chk_elem  <= elem;
      chk_bg    <= bg;

      if (miscmp && !bist_fail) begin
        bist_fail <= 1'b1;
        fail_addr <= chk_addr;
        fail_elem <= chk_elem;
        fail_bg   <= chk_bg;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= RUN;
            busy          <= 1'b1;
            bist_done     <= 1'b0;
            bist_fail     <= 1'b0;
            fail_addr     <= '0;
            fail_elem     <= '0;
            fail_bg       <= '0;
            bg            <= '0;
            elem          <= '0;
            idx           <= '0;
            ph            <= 1'b0;
            mem.mem_cs    <= 1'b1;
            mem.mem_we    <= 1'b1;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= bg_pattern(2'd0);
            pattern_0     <= bg_pattern(2'd0);
            pattern_1     <= ~bg_pattern(2'd0);
          end
        end
        RUN: begin
          if (last_op || (STOP_ON_FAIL && miscmp)) begin
            state      <= DRAIN;
            mem.mem_cs <= 1'b0;
            mem.mem_we <= 1'b0;
          end else begin
            bg            <= nxt_bg;
            elem          <= nxt_elem;
            idx           <= nxt_idx;
            ph            <= nxt_ph;
            mem.mem_cs    <= 1'b1;
            mem.mem_we    <= nxt_we;
            mem.mem_addr  <= nxt_addr;
            mem.mem_wdata <= nxt_data;
            pattern_0     <= nxt_p0;
            pattern_1     <= ~nxt_p0;
          end
        end
        DRAIN: begin
          state     <= DONE;
          busy      <= 1'b0;
          bist_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
